soc_system_cmd_in: RTL and testbench

- HPS-to-fabric command port: Avalon-MM slave that the HPS writes 32-bit command words into, buffered in a small FIFO.
- Words are presented to the matrix coprocessor over a valid/ready stream.
- Complements the read-only result PIO, which carries data fabric-to-HPS.
- Adds status/control registers so software can poll fullness, detect dropped words, flush, and pause delivery.

---
 rtl/soc_system_cmd_in_if.sv | 24 ++
 rtl/soc_system_cmd_in.sv | 135 +++++++++++++
 tb/tb_soc_system_cmd_in.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/soc_system_cmd_in_if.sv
// Command-port bundle. It carries the Avalon-MM register access from the HPS
// and the valid/ready command stream toward the matrix coprocessor.
interface soc_system_cmd_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        out_valid;
  logic        out_ready;

  // Host side: this is the Avalon master and also the stream consumer.
  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_port, out_valid
  );

  // Command port side: this is the Avalon slave and also the stream producer.
  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid
  );
endinterface

// File: rtl/soc_system_cmd_in.sv
// HPS-to-fabric command port. Words written to the DATA register are queued in
// a small FIFO. They are presented first-word-fall-through on a valid/ready
// stream. STATUS and CONTROL registers let software poll fullness, see dropped
// words, flush the queue and pause delivery.
module soc_system_cmd_in #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  soc_system_cmd_in_if.slave bus
);

  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          overflow_reg;
  logic          enable_reg;
  logic [31:0]   last_wr_reg;
  logic [31:0]   readdata_reg;
  logic [31:0]   readdata_next;

  logic wr;
  logic data_wr;
  logic status_wr;
  logic ctrl_wr;
  logic flush;
  logic full;
  logic empty;
  logic out_valid;
  logic pop;
  logic push;
  logic drop;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign data_wr   = wr & (bus.address == 2'd0);
  assign status_wr = wr & (bus.address == 2'd1);
  assign ctrl_wr   = wr & (bus.address == 2'd2);
  assign flush     = ctrl_wr & bus.writedata[1];

  assign full  = (count_reg == COUNT_FULL);
  assign empty = (count_reg == '0);

  // A pop frees a slot in the same cycle, so a write to a full FIFO that is
  // draining is still accepted.
  assign out_valid = enable_reg & ~empty;
  assign pop       = out_valid & bus.out_ready;
  assign push      = data_wr & (~full | pop);
  assign drop      = data_wr & full & ~pop;

  assign bus.out_valid = out_valid;
  assign bus.out_port  = out_valid ? mem[rd_ptr_reg] : 32'd0;
  assign bus.readdata  = readdata_reg;

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + COUNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - COUNT_ONE;
    end
  end

  // Register read mux. It samples state before this edge's updates.
  always_comb begin
    readdata_next = 32'd0;
    case (bus.address)
      2'd0:    readdata_next = last_wr_reg;
      2'd1:    readdata_next = {23'd0, overflow_reg, 6'(count_reg), full, empty};
      2'd2:    readdata_next = {31'd0, enable_reg};
      default: readdata_next = 32'd0;
    endcase
  end

  // FIFO storage. It has no reset, because occupancy is tracked by count and
  // the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.writedata;
    end
  end

  // Pointers and count. A flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
    end
  end

  // Control and status registers. A drop sets overflow, and the set beats a
  // same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
      enable_reg   <= 1'b1;
      last_wr_reg  <= 32'd0;
      readdata_reg <= 32'd0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (status_wr && bus.writedata[8]) begin
        overflow_reg <= 1'b0;
      end
      if (ctrl_wr) begin
        enable_reg <= bus.writedata[0];
      end
      if (data_wr) begin
        last_wr_reg <= bus.writedata;
      end
      readdata_reg <= readdata_next;
    end
  end

endmodule

// File: tb/tb_soc_system_cmd_in.sv
// Directed bench for the command port. Accepted DATA words are queued as
// expected stream output. Each handshake on the stream pops the queue and
// compares the word. Register reads are checked against fixed values.
module tb_soc_system_cmd_in;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  bit skip_mon = 1'b0;

  always #5 clk = ~clk;

  soc_system_cmd_in_if bus ();

  soc_system_cmd_in #(.DEPTH(4), .AW(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard the stream handshake just before the edge, then advance one clock.
  task automatic tick();
    logic [31:0] e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && !skip_mon) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL stream_extra: observed=0x%08h expected=none", bus.out_port);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stream_word", bus.out_port, e);
        $display("pop   word=0x%08h expected=0x%08h", bus.out_port, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic avs_write(input logic [1:0] addr, input logic [31:0] data,
                           input bit accept, input bit is_flush);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    if (addr == 2'd0 && accept) exp_q.push_back(data);
    skip_mon = is_flush;
    tick();
    if (is_flush) exp_q.delete();
    skip_mon       = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    $display("write addr=%0d data=0x%08h", addr, data);
  endtask

  task automatic read_reg(input logic [1:0] addr, input string tag, input logic [31:0] exp);
    bus.address = addr;
    tick();
    check(tag, bus.readdata, exp);
    $display("read  addr=%0d data=0x%08h expected=0x%08h", addr, bus.readdata, exp);
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    bus.out_ready  = 1'b0;

    // 1: reset state
    #1;
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_out_port", bus.out_port, 32'd0);
    read_reg(2'd1, "rst_status", 32'h0000_0001);
    read_reg(2'd2, "rst_control", 32'h0000_0001);

    // 2: fill, overflow, clear
    avs_write(2'd0, 32'h11, 1'b1, 1'b0);
    avs_write(2'd0, 32'h22, 1'b1, 1'b0);
    avs_write(2'd0, 32'h33, 1'b1, 1'b0);
    avs_write(2'd0, 32'h44, 1'b1, 1'b0);
    check("full_head", bus.out_port, 32'h11);
    read_reg(2'd1, "full_status", 32'h0000_0012);
    avs_write(2'd0, 32'h55, 1'b0, 1'b0);
    read_reg(2'd1, "ovf_status", 32'h0000_0112);
    read_reg(2'd0, "last_wr", 32'h0000_0055);
    avs_write(2'd1, 32'h100, 1'b0, 1'b0);
    read_reg(2'd1, "ovf_cleared", 32'h0000_0012);

    // 3: drain back to back
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check("drain3_valid", {31'd0, bus.out_valid}, 32'd0);
    check("drain3_left", exp_q.size(), 32'd0);
    read_reg(2'd1, "drain3_status", 32'h0000_0001);

    // 4: write into a full FIFO while it pops
    avs_write(2'd0, 32'h11, 1'b1, 1'b0);
    avs_write(2'd0, 32'h22, 1'b1, 1'b0);
    avs_write(2'd0, 32'h33, 1'b1, 1'b0);
    avs_write(2'd0, 32'h44, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    avs_write(2'd0, 32'h66, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    read_reg(2'd1, "pushpop_status", 32'h0000_0012);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    check("drain4_left", exp_q.size(), 32'd0);
    check("drain4_valid", {31'd0, bus.out_valid}, 32'd0);

    // 5: pause and resume
    avs_write(2'd0, 32'h0A, 1'b1, 1'b0);
    avs_write(2'd0, 32'h0B, 1'b1, 1'b0);
    avs_write(2'd2, 32'h0, 1'b0, 1'b0);
    check("pause_valid", {31'd0, bus.out_valid}, 32'd0);
    check("pause_port", bus.out_port, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    read_reg(2'd1, "pause_status", 32'h0000_0008);
    avs_write(2'd2, 32'h1, 1'b0, 1'b0);
    check("resume_port", bus.out_port, 32'h0000_000A);
    check("resume_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (2) tick();
    bus.out_ready = 1'b0;
    check("drain5_left", exp_q.size(), 32'd0);

    // 6: flush with a concurrent pop, then async reset mid-stream
    avs_write(2'd0, 32'h1, 1'b1, 1'b0);
    avs_write(2'd0, 32'h2, 1'b1, 1'b0);
    avs_write(2'd0, 32'h3, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    avs_write(2'd2, 32'h3, 1'b0, 1'b1);
    check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_port", bus.out_port, 32'd0);
    bus.out_ready = 1'b0;
    read_reg(2'd1, "flush_status", 32'h0000_0001);
    read_reg(2'd2, "flush_control", 32'h0000_0001);
    avs_write(2'd0, 32'h7, 1'b1, 1'b0);
    avs_write(2'd0, 32'h8, 1'b1, 1'b0);
    bus.address = 2'd1;
    bus.out_ready = 1'b1;
    tick();
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_port", bus.out_port, 32'd0);
    check("async_rst_readdata", bus.readdata, 32'd0);
    exp_q.delete();
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(2'd1, "post_rst_status", 32'h0000_0001);
    read_reg(2'd0, "post_rst_last_wr", 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
